bp_be_late_wb_arbiter: RTL and testbench
========================================

// Module: bp_be_late_wb_arbiter
//
// PURPOSE
// - Producer side of the late-writeback scoreboard protocol. Long-latency result sources
//   (dcache load-miss fill, idiv, fdiv, ...) post results here. Each posted result was scored
//   at dispatch or commit.
// - Block arbitrates int and fp results separately and buffers them per register file.
// - Each cycle it emits at most one late iwb write and one late fwb write, marked late=1.
//   Each emitted write clears the matching scoreboard entry.
// - idle_o reports that no scored register is outstanding; fence/ordering logic consumes it.
//
// PARAMETERS
// - num_src_p    3   number of late result sources
// - fifo_els_p   2   entries in each of the int and fp output FIFOs (power of 2, >=2)
// - dword_width  64  result data width (shared package constant dword_width_gp)
// - rd_width     5   register address width (reg_addr_width_gp)
//
// PORTS
// - clk_i          in   1              clock, rising edge
// - reset_n_i      in   1              asynchronous active-low reset
// - src_v_i        in   num_src_p      source i has a result
// - src_ready_o    out  num_src_p      source i result accepted this cycle
// - src_fp_i       in   num_src_p      1 = result targets the fp regfile, 0 = int regfile
// - src_rd_addr_i  in   num_src_p*5    destination register, per source
// - src_data_i     in   num_src_p*64   result data, per source
// - src_fflags_i   in   num_src_p*5    fp exception flags, per source (ignored for int)
// - score_int_v_i  in   1              int scoreboard set this cycle
// - score_fp_v_i   in   1              fp scoreboard set this cycle
// - iwb_busy_i     in   1              early writeback owns the int write port this cycle
// - fwb_busy_i     in   1              early writeback owns the fp write port this cycle
// - iwb_v_o        out  1              late int write valid (ird_w_v=1, late=1)
// - iwb_rd_addr_o  out  5              late int write destination
// - iwb_data_o     out  64             late int write data
// - fwb_v_o        out  1              late fp write valid (frd_w_v=1, late=1)
// - fwb_rd_addr_o  out  5              late fp write destination
// - fwb_data_o     out  64             late fp write data
// - fwb_fflags_o   out  5              late fp write flags
// - idle_o         out  1              both FIFOs empty and both outstanding counts zero
//
// BEHAVIOUR
// - Reset (reset_n_i=0, async):
//   - FIFOs empty; RR pointers = 0; counters = 0.
//   - All *_v_o and src_ready_o = 0; data and address outputs = 0; idle_o = 1.
//   - Reset mid-operation discards buffered results. The scoreboard resets in the same domain.
// - Arbitration, one independent round-robin arbiter per file:
//   - Int candidates are src_v_i & ~src_fp_i. Fp candidates are src_v_i & src_fp_i.
//   - The winner is the first candidate at or after the file's RR pointer.
//   - A grant is issued only if the file's FIFO can accept: not full, or full with a pop
//     this cycle (pop-before-push).
//   - src_ready_o[i] = granted.
//   - On a grant, the pointer advances to (winner+1) mod num_src_p. With no grant it holds.
// - Sources hold src_v_i and their payload until ready. A source is granted at most once
//   per cycle.
// - Latency: result accepted in cycle N is visible on *_v_o no earlier than N+1.
//   There is no bypass path.
// - Emit:
//   - iwb_v_o = int FIFO not empty & ~iwb_busy_i.
//   - The head is popped in the same cycle as iwb_v_o.
//   - Outputs show the head while it is stalled by busy; the head holds until emitted.
//   - The fp path is the same, using fwb_busy_i.
//   - Int and fp may emit in the same cycle.
// - Outstanding counters, 6 bits each, per file:
//   - cnt_n = cnt + score_v_i - emit_v.
//   - Simultaneous score and emit leaves cnt unchanged.
//   - Assert no underflow (emit with cnt=0) and no overflow (cnt>32).
// - idle_o = ~|int_cnt & ~|fp_cnt & both FIFOs empty. Registered: derived from the state
//   after the edge.
// - No flush input. Scored results always retire, because the scoreboard must be cleared.
//
// STRUCTURE
// - Shared package (bp_be_pkg):
//   - typedef bp_be_late_wb_s {rd_addr, data, fflags}.
//   - Uses constants reg_addr_width_gp and dword_width_gp.
// - One sub-module, bp_be_late_wb_rr_arb: round-robin grant plus pointer. Instantiated
//   twice (int, fp).
// - FIFOs: two instances of the existing two-pointer FIFO with a full/empty wrap bit.
//
// TESTING
// - Single int result: src0 v, rd=5, data=0xDEAD at N, with score_int_v_i pulsed earlier
//   -> src_ready_o[0]=1 at N; iwb_v_o=1, rd=5, data=0xDEAD at N+1; idle_o=1 after.
// - Round-robin: src0 and src1 int, both v for 3 cycles, pointer=0
//   -> grants src0, src1, src0; iwb order matches the grants.
// - Port busy: iwb_busy_i=1 for 4 cycles, FIFO holding rd=7
//   -> iwb_v_o=0 throughout; rd=7 emitted on the first cycle busy=0.
// - Backpressure: busy held, 3 int results offered, fifo_els_p=2
//   -> 2 accepted, third src_ready_o=0 until busy drops; then the third is accepted in the
//      same cycle the head pops.
// - Dual file: int rd=3 from src0 and fp rd=9, fflags=0x1 from src2 in the same cycle
//   -> iwb_v_o and fwb_v_o both 1 next cycle; fwb_fflags_o=0x1.
// - Async reset: assert reset_n_i=0 mid-cycle with both FIFOs holding results
//   -> all outputs 0 and idle_o=1 immediately; no emission after release.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared back-end types and widths for the late writeback path.
// One entry holds a result waiting for a free regfile write port.
package bp_be_pkg;

  localparam int reg_addr_width_gp = 5;
  localparam int dword_width_gp    = 64;
  localparam int fflags_width_gp   = 5;

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]    data;
    logic [fflags_width_gp-1:0]   fflags;
  } bp_be_late_wb_s;

endpackage

// File: rtl/bp_be_late_wb_fifo.sv
// Two-pointer FIFO with a wrap bit for full/empty.
// Head is read combinationally; push and pop may share a cycle.
module bp_be_late_wb_fifo
  import bp_be_pkg::*;
#(
  parameter int els_p = 2
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           push_i,
  input  bp_be_late_wb_s data_i,
  input  logic           pop_i,
  output bp_be_late_wb_s data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int aw = $clog2(els_p);

  bp_be_late_wb_s mem_q [els_p];
  logic [aw:0]    wptr_q;
  logic [aw:0]    rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[aw] != rptr_q[aw])
                 & (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
  assign data_o  = mem_q[rptr_q[aw-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) begin
        wptr_q <= wptr_q + (aw+1)'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + (aw+1)'(1);
      end
    end
  end

  // storage needs no reset; empty gates everything downstream
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q[aw-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/bp_be_late_wb_rr_arb.sv
// Round-robin grant for one register file.
// Winner is the first request at or after the pointer.
module bp_be_late_wb_rr_arb #(
  parameter int num_src_p = 3,
  localparam int ptr_w = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_src_p-1:0] req_i,
  input  logic                 en_i,
  output logic [num_src_p-1:0] grant_o,
  output logic [ptr_w-1:0]     win_o,
  output logic                 v_o
);

  localparam int iw = ptr_w + 1;

  logic [ptr_w-1:0] ptr_q;
  logic [ptr_w-1:0] ptr_n;
  logic [iw-1:0]    idx;
  logic             found;

  always_comb begin
    found = 1'b0;
    win_o = '0;
    idx   = '0;
    for (int i = 0; i < num_src_p; i++) begin
      idx = {1'b0, ptr_q} + iw'(i);
      if (idx >= iw'(num_src_p)) begin
        idx = idx - iw'(num_src_p);
      end
      if (!found && req_i[idx[ptr_w-1:0]]) begin
        found = 1'b1;
        win_o = idx[ptr_w-1:0];
      end
    end
  end

  assign v_o = found & en_i;

  always_comb begin
    grant_o = '0;
    if (v_o) begin
      grant_o[win_o] = 1'b1;
    end
  end

  always_comb begin
    ptr_n = ptr_q;
    if (v_o) begin
      if (win_o == ptr_w'(num_src_p - 1)) begin
        ptr_n = '0;
      end else begin
        ptr_n = win_o + ptr_w'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_n;
    end
  end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Late writeback arbiter: int and fp results are arbitrated, buffered
// and retired through the late iwb/fwb ports, clearing the scoreboard.
module bp_be_late_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int num_src_p  = 3,
  parameter int fifo_els_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [num_src_p-1:0] src_v_i,
  output logic [num_src_p-1:0] src_ready_o,
  input  logic [num_src_p-1:0] src_fp_i,
  input  logic [num_src_p*reg_addr_width_gp-1:0] src_rd_addr_i,
  input  logic [num_src_p*dword_width_gp-1:0] src_data_i,
  input  logic [num_src_p*fflags_width_gp-1:0] src_fflags_i,
  input  logic score_int_v_i,
  input  logic score_fp_v_i,
  input  logic iwb_busy_i,
  input  logic fwb_busy_i,
  output logic iwb_v_o,
  output logic [reg_addr_width_gp-1:0] iwb_rd_addr_o,
  output logic [dword_width_gp-1:0] iwb_data_o,
  output logic fwb_v_o,
  output logic [reg_addr_width_gp-1:0] fwb_rd_addr_o,
  output logic [dword_width_gp-1:0] fwb_data_o,
  output logic [fflags_width_gp-1:0] fwb_fflags_o,
  output logic idle_o
);

  localparam int ptr_w = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int aw    = reg_addr_width_gp;
  localparam int dw    = dword_width_gp;
  localparam int fw    = fflags_width_gp;
  localparam int cnt_w = 6;

  logic [num_src_p-1:0] int_req;
  logic [num_src_p-1:0] fp_req;
  logic [num_src_p-1:0] int_gnt;
  logic [num_src_p-1:0] fp_gnt;
  logic [ptr_w-1:0]     int_win;
  logic [ptr_w-1:0]     fp_win;
  logic int_push, int_pop, int_full, int_empty, int_en;
  logic fp_push, fp_pop, fp_full, fp_empty, fp_en;
  bp_be_late_wb_s int_wr, int_head;
  bp_be_late_wb_s fp_wr, fp_head;
  logic [cnt_w-1:0] int_cnt_q, int_cnt_n;
  logic [cnt_w-1:0] fp_cnt_q, fp_cnt_n;
  logic int_fflags_unused;

  assign int_req = src_v_i & ~src_fp_i;
  assign fp_req  = src_v_i & src_fp_i;

  assign int_pop = ~int_empty & ~iwb_busy_i;
  assign fp_pop  = ~fp_empty & ~fwb_busy_i;

  // a full FIFO still accepts when its head leaves this cycle
  assign int_en = reset_n_i & (~int_full | int_pop);
  assign fp_en  = reset_n_i & (~fp_full | fp_pop);

  bp_be_late_wb_rr_arb #(
    .num_src_p(num_src_p)
  ) int_arb (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .req_i    (int_req),
    .en_i     (int_en),
    .grant_o  (int_gnt),
    .win_o    (int_win),
    .v_o      (int_push)
  );

  bp_be_late_wb_rr_arb #(
    .num_src_p(num_src_p)
  ) fp_arb (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .req_i    (fp_req),
    .en_i     (fp_en),
    .grant_o  (fp_gnt),
    .win_o    (fp_win),
    .v_o      (fp_push)
  );

  assign src_ready_o = int_gnt | fp_gnt;

  always_comb begin
    int_wr         = '0;
    fp_wr          = '0;
    int_wr.rd_addr = src_rd_addr_i[int_win*aw +: aw];
    int_wr.data    = src_data_i[int_win*dw +: dw];
    fp_wr.rd_addr  = src_rd_addr_i[fp_win*aw +: aw];
    fp_wr.data     = src_data_i[fp_win*dw +: dw];
    fp_wr.fflags   = src_fflags_i[fp_win*fw +: fw];
  end

  bp_be_late_wb_fifo #(
    .els_p(fifo_els_p)
  ) int_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (int_push),
    .data_i   (int_wr),
    .pop_i    (int_pop),
    .data_o   (int_head),
    .full_o   (int_full),
    .empty_o  (int_empty)
  );

  bp_be_late_wb_fifo #(
    .els_p(fifo_els_p)
  ) fp_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (fp_push),
    .data_i   (fp_wr),
    .pop_i    (fp_pop),
    .data_o   (fp_head),
    .full_o   (fp_full),
    .empty_o  (fp_empty)
  );

  assign int_fflags_unused = ^int_head.fflags;

  assign iwb_v_o       = int_pop;
  assign iwb_rd_addr_o = int_empty ? '0 : int_head.rd_addr;
  assign iwb_data_o    = int_empty ? '0 : int_head.data;

  assign fwb_v_o       = fp_pop;
  assign fwb_rd_addr_o = fp_empty ? '0 : fp_head.rd_addr;
  assign fwb_data_o    = fp_empty ? '0 : fp_head.data;
  assign fwb_fflags_o  = fp_empty ? '0 : fp_head.fflags;

  assign int_cnt_n = int_cnt_q
                   + cnt_w'(score_int_v_i)
                   - cnt_w'(iwb_v_o);
  assign fp_cnt_n  = fp_cnt_q
                   + cnt_w'(score_fp_v_i)
                   - cnt_w'(fwb_v_o);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      int_cnt_q <= '0;
      fp_cnt_q  <= '0;
    end else begin
      int_cnt_q <= int_cnt_n;
      fp_cnt_q  <= fp_cnt_n;
    end
  end

  assign idle_o = ~|int_cnt_q & ~|fp_cnt_q
                & int_empty & fp_empty;

  a_int_under: assert property (@(posedge clk_i)
    disable iff (!reset_n_i) !(iwb_v_o && int_cnt_q == '0));
  a_fp_under: assert property (@(posedge clk_i)
    disable iff (!reset_n_i) !(fwb_v_o && fp_cnt_q == '0));
  a_int_over: assert property (@(posedge clk_i)
    disable iff (!reset_n_i) int_cnt_q <= cnt_w'(32));
  a_fp_over: assert property (@(posedge clk_i)
    disable iff (!reset_n_i) fp_cnt_q <= cnt_w'(32));

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Bench for the late writeback arbiter: directed cases with literal
// expectations, then random traffic against a queue-based model.
module tb_bp_be_late_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  src_v, src_fp, src_ready;
  logic [14:0] src_rd, src_ff;
  logic [191:0] src_data;
  logic        score_i, score_f, ibusy, fbusy;
  logic        iv, fv, idle;
  logic [4:0]  ird, frd, fff;
  logic [63:0] idat, fdat;

  bp_be_late_wb_arbiter dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .src_v_i      (src_v),
    .src_ready_o  (src_ready),
    .src_fp_i     (src_fp),
    .src_rd_addr_i(src_rd),
    .src_data_i   (src_data),
    .src_fflags_i (src_ff),
    .score_int_v_i(score_i),
    .score_fp_v_i (score_f),
    .iwb_busy_i   (ibusy),
    .fwb_busy_i   (fbusy),
    .iwb_v_o      (iv),
    .iwb_rd_addr_o(ird),
    .iwb_data_o   (idat),
    .fwb_v_o      (fv),
    .fwb_rd_addr_o(frd),
    .fwb_data_o   (fdat),
    .fwb_fflags_o (fff),
    .idle_o       (idle)
  );

  int vec = 0;
  int err = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // behavioural model: per-file queue, rotating priority, counts
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
    logic [4:0]  f;
  } ent_t;

  ent_t       mq [2][$];
  int         mptr [2];
  int         mcnt [2];
  logic [2:0] m_gnt = '0;
  bit         e_emit [2];
  bit         won [2];
  int         wj [2];
  bit         busy [2];
  bit         sc [2];
  int         j;
  bit         e_idle;
  ent_t       h, ne;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      for (int f = 0; f < 2; f++) begin
        mq[f].delete();
        mptr[f] = 0;
        mcnt[f] = 0;
      end
      m_gnt = '0;
    end else begin
      e_idle = mcnt[0] == 0 && mcnt[1] == 0
            && mq[0].size() == 0 && mq[1].size() == 0;
      busy[0] = ibusy;
      busy[1] = fbusy;
      sc[0] = score_i;
      sc[1] = score_f;
      m_gnt = '0;
      for (int f = 0; f < 2; f++) begin
        e_emit[f] = mq[f].size() > 0 && !busy[f];
        won[f] = 0;
        wj[f] = 0;
        if (mq[f].size() < 2 || e_emit[f]) begin
          for (int k = 0; k < 3; k++) begin
            j = (mptr[f] + k) % 3;
            if (!won[f] && src_v[j] && (src_fp[j] == (f == 1))) begin
              won[f] = 1;
              wj[f] = j;
              m_gnt[j] = 1'b1;
            end
          end
        end
      end
      chk("ready", src_ready, m_gnt);
      chk("idle", idle, e_idle);
      h = '{default: '0};
      if (mq[0].size() > 0) h = mq[0][0];
      chk("iwb_v", iv, e_emit[0]);
      chk("iwb_rd", ird, h.rd);
      chk("iwb_data", idat, h.d);
      h = '{default: '0};
      if (mq[1].size() > 0) h = mq[1][0];
      chk("fwb_v", fv, e_emit[1]);
      chk("fwb_rd", frd, h.rd);
      chk("fwb_data", fdat, h.d);
      chk("fwb_fflags", fff, h.f);
      for (int f = 0; f < 2; f++) begin
        if (e_emit[f]) void'(mq[f].pop_front());
        if (won[f]) begin
          ne.rd = src_rd[wj[f]*5 +: 5];
          ne.d  = src_data[wj[f]*64 +: 64];
          ne.f  = (f == 1) ? src_ff[wj[f]*5 +: 5] : 5'd0;
          mq[f].push_back(ne);
          mptr[f] = (wj[f] + 1) % 3;
        end
        mcnt[f] = mcnt[f] + int'(sc[f]) - int'(e_emit[f]);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic post(int i, bit fp, logic [4:0] rd,
                      logic [63:0] d, logic [4:0] f);
    src_v[i] = 1'b1;
    src_fp[i] = fp;
    src_rd[i*5 +: 5] = rd;
    src_data[i*64 +: 64] = d;
    src_ff[i*5 +: 5] = f;
  endtask

  task automatic quiet();
    src_v = '0;
    score_i = 0;
    score_f = 0;
    ibusy = 0;
    fbusy = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    quiet();
    mid();
    nxt();
    reset_n = 1;
  endtask

  int  avail [2];
  bit  fp;
  int  guard;

  initial begin
    reset_n = 0;
    quiet();
    src_fp = '0;
    src_rd = '0;
    src_data = '0;
    src_ff = '0;
    post(0, 0, 5'd1, 64'h1, 5'd0);
    post(1, 1, 5'd2, 64'h2, 5'd1);
    #2;
    chk("rst_ready", src_ready, 3'b000);
    chk("rst_iv", iv, 0);
    chk("rst_fv", fv, 0);
    chk("rst_ird", ird, 0);
    chk("rst_idat", idat, 0);
    chk("rst_frd", frd, 0);
    chk("rst_fdat", fdat, 0);
    chk("rst_fff", fff, 0);
    chk("rst_idle", idle, 1);
    src_v = '0;
    nxt();
    nxt();
    reset_n = 1;

    // single int result
    score_i = 1;
    mid(); nxt();
    score_i = 0;
    post(0, 0, 5'd5, 64'hDEAD, 5'd0);
    mid();
    chk("t1_ready", src_ready, 3'b001);
    chk("t1_idle0", idle, 0);
    nxt();
    src_v[0] = 0;
    mid();
    chk("t1_iv", iv, 1);
    chk("t1_rd", ird, 5);
    chk("t1_data", idat, 64'hDEAD);
    nxt();
    mid();
    chk("t1_idle1", idle, 1);
    nxt();

    // round robin src0/src1
    do_reset();
    score_i = 1;
    repeat (4) begin mid(); nxt(); end
    score_i = 0;
    post(0, 0, 5'd1, 64'h11, 5'd0);
    post(1, 0, 5'd2, 64'h22, 5'd0);
    mid(); chk("rr_g1", src_ready, 3'b001); nxt();
    post(0, 0, 5'd3, 64'h33, 5'd0);
    mid(); chk("rr_g2", src_ready, 3'b010);
    chk("rr_e1", ird, 1); nxt();
    post(1, 0, 5'd4, 64'h44, 5'd0);
    mid(); chk("rr_g3", src_ready, 3'b001);
    chk("rr_e2", ird, 2); nxt();
    src_v[0] = 0;
    mid(); chk("rr_g4", src_ready, 3'b010);
    chk("rr_e3", ird, 3); nxt();
    src_v[1] = 0;
    mid(); chk("rr_e4", ird, 4); nxt();
    mid(); nxt();

    // port busy
    do_reset();
    score_i = 1;
    mid(); nxt();
    score_i = 0;
    ibusy = 1;
    post(0, 0, 5'd7, 64'h77, 5'd0);
    mid(); chk("bz_ready", src_ready, 3'b001); nxt();
    src_v[0] = 0;
    repeat (4) begin
      mid();
      chk("bz_hold_v", iv, 0);
      chk("bz_hold_rd", ird, 7);
      nxt();
    end
    ibusy = 0;
    mid();
    chk("bz_emit_v", iv, 1);
    chk("bz_emit_rd", ird, 7);
    nxt();

    // backpressure with a two-entry FIFO
    do_reset();
    score_i = 1;
    repeat (3) begin mid(); nxt(); end
    score_i = 0;
    ibusy = 1;
    post(0, 0, 5'd1, 64'hA1, 5'd0);
    post(1, 0, 5'd2, 64'hA2, 5'd0);
    post(2, 0, 5'd3, 64'hA3, 5'd0);
    mid(); chk("bp_g1", src_ready, 3'b001); nxt();
    src_v[0] = 0;
    mid(); chk("bp_g2", src_ready, 3'b010); nxt();
    src_v[1] = 0;
    mid(); chk("bp_full1", src_ready, 3'b000); nxt();
    mid(); chk("bp_full2", src_ready, 3'b000); nxt();
    ibusy = 0;
    mid();
    chk("bp_g3", src_ready, 3'b100);
    chk("bp_pop_v", iv, 1);
    chk("bp_pop_rd", ird, 1);
    nxt();
    src_v[2] = 0;
    mid(); chk("bp_e2", ird, 2); nxt();
    mid(); chk("bp_e3", ird, 3); nxt();

    // int and fp in the same cycle
    do_reset();
    score_i = 1;
    score_f = 1;
    mid(); nxt();
    score_i = 0;
    score_f = 0;
    post(0, 0, 5'd3, 64'hC3, 5'd0);
    post(2, 1, 5'd9, 64'hF9, 5'h1);
    mid(); chk("df_ready", src_ready, 3'b101); nxt();
    src_v = '0;
    mid();
    chk("df_iv", iv, 1);
    chk("df_fv", fv, 1);
    chk("df_ird", ird, 3);
    chk("df_frd", frd, 9);
    chk("df_fff", fff, 5'h1);
    nxt();

    // async reset with both FIFOs occupied
    do_reset();
    score_i = 1;
    score_f = 1;
    mid(); nxt();
    score_i = 0;
    score_f = 0;
    ibusy = 1;
    fbusy = 1;
    post(0, 0, 5'd12, 64'hBEEF, 5'd0);
    post(1, 1, 5'd13, 64'hCAFE, 5'd3);
    mid(); nxt();
    src_v = '0;
    mid();
    chk("ar_pre_ird", ird, 12);
    chk("ar_pre_frd", frd, 13);
    reset_n = 0;
    ibusy = 0;
    fbusy = 0;
    post(2, 0, 5'd14, 64'h14, 5'd0);
    #1;
    chk("ar_iv", iv, 0);
    chk("ar_fv", fv, 0);
    chk("ar_ird", ird, 0);
    chk("ar_idat", idat, 0);
    chk("ar_frd", frd, 0);
    chk("ar_fdat", fdat, 0);
    chk("ar_fff", fff, 0);
    chk("ar_ready", src_ready, 0);
    chk("ar_idle", idle, 1);
    nxt();
    mid(); nxt();
    src_v = '0;
    reset_n = 1;
    repeat (2) begin
      mid();
      chk("ar_post_iv", iv, 0);
      chk("ar_post_fv", fv, 0);
      nxt();
    end

    // random traffic
    avail[0] = 0;
    avail[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      src_v = src_v & ~m_gnt;
      for (int i = 0; i < 3; i++) begin
        if (!src_v[i] && $urandom_range(0, 2) == 0) begin
          fp = 1'($urandom_range(0, 1));
          if (avail[fp] == 0) fp = ~fp;
          if (avail[fp] > 0) begin
            avail[fp]--;
            post(i, fp, 5'($urandom), {$urandom, $urandom},
                 5'($urandom));
          end
        end
      end
      score_i = (mcnt[0] < 30) && ($urandom_range(0, 1) == 1);
      score_f = (mcnt[1] < 30) && ($urandom_range(0, 1) == 1);
      if (score_i) avail[0]++;
      if (score_f) avail[1]++;
      ibusy = ($urandom_range(0, 3) == 0);
      fbusy = ($urandom_range(0, 3) == 0);
      mid();
      nxt();
    end

    // drain everything that was scored
    score_i = 0;
    score_f = 0;
    ibusy = 0;
    fbusy = 0;
    guard = 0;
    while (!(mcnt[0] == 0 && mcnt[1] == 0 && src_v == '0
             && avail[0] == 0 && avail[1] == 0
             && mq[0].size() == 0 && mq[1].size() == 0)
           && guard < 400) begin
      src_v = src_v & ~m_gnt;
      for (int i = 0; i < 3; i++) begin
        if (!src_v[i]) begin
          for (int f = 0; f < 2; f++) begin
            if (!src_v[i] && avail[f] > 0) begin
              avail[f]--;
              post(i, f == 1, 5'($urandom), {$urandom, $urandom},
                   5'($urandom));
            end
          end
        end
      end
      mid();
      nxt();
      guard++;
    end
    vec++;
    if (guard >= 400) begin
      err++;
      $display("FAIL drain_timeout got=%0d exp=<400", guard);
    end
    mid();
    chk("final_idle", idle, 1);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
